keypad_conditioner: RTL and testbench
=====================================

# keypad_conditioner

Input-conditioning stage that sits directly upstream of the car simulator top level. It takes the twelve raw, bouncing, asynchronous keypad lines and produces synchronized, debounced key levels, single-cycle press and release pulses, and long-hold flags. It also encodes gear-selection presses into one gear request. The top-level engine-start, gear, brake and horn logic consume these outputs instead of raw pins.

## Interface
Parameters:
- CLK_HZ, 50_000_000: CLK frequency. Sets the 1 ms tick prescaler (CLK_HZ/1000 cycles per tick).
- DEBOUNCE_MS, 20: consecutive ms a raw level must differ from the debounced level before it is accepted (1..31).
- HOLD_MS, 1000: ms a debounced key must stay pressed before key_hold asserts (1..1023).

Ports:
- CLK  in  1  system clock.
- global_safe_rst  in  1  asynchronous, active-high reset.
- key_raw  in  12  raw keys, active-high, asynchronous to CLK. Bit mapping:
  - bits 0..8 = KEY_1..KEY_9
  - bit 9 = KEY_STAR
  - bit 10 = KEY_0
  - bit 11 = KEY_SHARP
- key_level  out  12  debounced key state, 1 = pressed.
- key_press  out  12  one-CLK pulse on a debounced 0->1 transition.
- key_release  out  12  one-CLK pulse on a debounced 1->0 transition.
- key_hold  out  12  level; 1 while the key has been continuously pressed for at least HOLD_MS ms.
- gear_req  out  4  last requested gear code: 3 = P, 6 = R, 9 = N, 12 = D.
- gear_req_valid  out  1  one-CLK pulse when gear_req is updated.

## Operation
- **Reset values:**
  - key_level, key_press, key_release, key_hold, gear_req_valid = 0.
  - gear_req = 3.
  - Prescaler, synchronizers and all counters are cleared.
- **Tick prescaler:** a counter runs 0..CLK_HZ/1000-1, then wraps. tick_1ms is a one-cycle strobe on the wrap cycle.
- **Synchronizer:** each key_raw bit passes through 2 flops to give sync[i]. Nothing else samples key_raw.
- **Debounce (per key i):** uses a 5-bit counter db_cnt[i].
  - If sync[i] == key_level[i], db_cnt[i] clears to 0 on the next edge, even mid-count.
  - If sync[i] != key_level[i] and tick_1ms: db_cnt[i] increments.
  - When the increment would reach DEBOUNCE_MS, on that same edge: key_level[i] takes sync[i], db_cnt[i] clears, and key_press[i] or key_release[i] is registered high for one cycle.
- **Hold (per key i):** uses a 10-bit counter hold_cnt[i].
  - Cleared while key_level[i] = 0.
  - While key_level[i] = 1, increments on tick_1ms and saturates at HOLD_MS.
  - key_hold[i] = (hold_cnt[i] == HOLD_MS), registered.
  - key_hold[i] drops on the same edge key_level[i] falls.
- **Gear encoder:** on any cycle where key_press has bit 2 (KEY_3), 5 (KEY_6), 8 (KEY_9) or 11 (KEY_SHARP) set:
  - gear_req is loaded with the highest-priority code: KEY_3 -> 3, then KEY_6 -> 6, then KEY_9 -> 9, then KEY_SHARP -> 12.
  - gear_req_valid pulses for one cycle, one edge after the key_press pulse.
  - A press of the key for the gear already selected still pulses gear_req_valid.
  - Holding a key does not repeat the request.
- **Independence:** the twelve keys are independent. Simultaneous transitions on several keys produce simultaneous pulses on the corresponding bits.

## Timing
- Raw edge to sync: 2 CLK cycles.
- Sync stable to key_level update: exactly DEBOUNCE_MS tick_1ms strobes, i.e. between (DEBOUNCE_MS-1) ms and DEBOUNCE_MS ms plus 1 cycle.
- Total raw to key_level latency: at most DEBOUNCE_MS ms + 3 cycles.
- key_press / key_release are high in the same cycle key_level first shows its new value, for exactly 1 cycle.
- key_hold asserts HOLD_MS tick_1ms strobes after key_level rises (±1 ms tick phase).
- gear_req and gear_req_valid update 1 cycle after key_press.
- **Glitch rejection:** a raw pulse or bounce shorter than the debounce window never changes key_level, because any return to key_level resets db_cnt.
- **Key held through reset:** after global_safe_rst deasserts, key_level rises DEBOUNCE_MS ms later with a key_press pulse (keys are never pre-loaded as pressed).
- **Reset mid-operation:** asynchronous assertion clears everything immediately, including in-flight pulses. No pulse is emitted on reset release.

## Test plan
Bench parameters: CLK_HZ=10_000 (tick every 10 cycles), DEBOUNCE_MS=4, HOLD_MS=20.
- Reset with key_raw=0 -> all outputs 0, gear_req=3, no pulses for 100 cycles.
- Clean KEY_0 press (bit 10 held high) -> key_level[10] rises 31..42 cycles after the raw edge with a 1-cycle key_press[10]; on raw release, a 1-cycle key_release[10] after the same latency.
- Bounce: bit 9 toggles every 15 cycles for 200 cycles, then stays high -> no key_press[9] during bouncing; exactly one key_press[9] within 42 cycles of settling.
- Hold: bit 0 held 300 cycles -> key_hold[0] rises about 200 cycles (20 ticks ±1) after key_level[0]; it clears on the edge key_level[0] falls.
- Gear: KEY_SHARP press -> gear_req=12 with gear_req_valid 1 cycle after key_press[11]. KEY_3 and KEY_6 raw edges in the same cycle -> gear_req=3, single valid pulse.
- Assert global_safe_rst while key_hold[4]=1 and KEY_5 still held -> all outputs 0 asynchronously. After release, key_press[4] fires 31..42 cycles later.

Source files
------------

// File: rtl/keypad_conditioner_if.sv
// Keypad conditioner bundle: raw key lines in, conditioned key/gear outputs back.
// master = conditioner side, slave = consumer (car top level) side.
interface keypad_conditioner_if;
  logic [11:0] key_raw;
  logic [11:0] key_level;
  logic [11:0] key_press;
  logic [11:0] key_release;
  logic [11:0] key_hold;
  logic [3:0]  gear_req;
  logic        gear_req_valid;

  modport master (
    input  key_raw,
    output key_level, key_press, key_release, key_hold, gear_req, gear_req_valid
  );

  modport slave (
    output key_raw,
    input  key_level, key_press, key_release, key_hold, gear_req, gear_req_valid
  );
endinterface

// File: rtl/keypad_conditioner.sv
// Keypad conditioner: 2-flop sync, per-key ms-tick debounce, press/release pulses, hold flags, gear encode.
// Latency: raw->key_level <= DEBOUNCE_MS ms + 3 cycles, gear_req 1 cycle after key_press; no backpressure (free-running).
module keypad_conditioner #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 1000
) (
  input logic                   CLK,
  input logic                   global_safe_rst,
  keypad_conditioner_if.master  kp
);

  localparam int              TICK_DIV   = CLK_HZ / 1000;
  localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [4:0]      DB_LIMIT   = 5'(DEBOUNCE_MS);
  localparam logic [9:0]      HOLD_LIMIT = 10'(HOLD_MS);
  localparam logic [11:0]     GEAR_MASK  = 12'b1001_0010_0100;

  logic [PW-1:0] pre_cnt;
  logic          tick_1ms;
  logic [11:0]   sync_meta;
  logic [11:0]   sync;

  logic [11:0]   level_q, press_q, release_q, hold_q;
  logic [11:0]   level_d, press_d, release_d, hold_d;
  logic [4:0]    db_cnt     [12];
  logic [4:0]    db_cnt_d   [12];
  logic [9:0]    hold_cnt   [12];
  logic [9:0]    hold_cnt_d [12];

  logic [3:0]    gear_q;
  logic          gear_vld_q;

  assign tick_1ms = (pre_cnt == TICK_LAST);

  always_ff @(posedge CLK or posedge global_safe_rst) begin
    if (global_safe_rst) begin
      pre_cnt   <= '0;
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      pre_cnt   <= tick_1ms ? '0 : pre_cnt + 1'b1;
      sync_meta <= kp.key_raw;
      sync      <= sync_meta;
    end
  end

  // Any cycle where sync agrees with the accepted level restarts the debounce window.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    hold_d    = '0;
    for (int i = 0; i < 12; i++) begin
      db_cnt_d[i]   = db_cnt[i];
      hold_cnt_d[i] = hold_cnt[i];
      if (sync[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (tick_1ms) begin
        if (db_cnt[i] + 5'd1 == DB_LIMIT) begin
          level_d[i]   = sync[i];
          db_cnt_d[i]  = '0;
          press_d[i]   = sync[i];
          release_d[i] = ~sync[i];
        end else begin
          db_cnt_d[i] = db_cnt[i] + 5'd1;
        end
      end
      if (!level_q[i]) begin
        hold_cnt_d[i] = '0;
      end else if (tick_1ms && (hold_cnt[i] != HOLD_LIMIT)) begin
        hold_cnt_d[i] = hold_cnt[i] + 10'd1;
      end
      // Gated by the next level so the flag falls on the same edge as the key.
      hold_d[i] = level_d[i] && (hold_cnt_d[i] == HOLD_LIMIT);
    end
  end

  always_ff @(posedge CLK or posedge global_safe_rst) begin
    if (global_safe_rst) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      hold_q    <= '0;
      for (int i = 0; i < 12; i++) begin
        db_cnt[i]   <= '0;
        hold_cnt[i] <= '0;
      end
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      for (int i = 0; i < 12; i++) begin
        db_cnt[i]   <= db_cnt_d[i];
        hold_cnt[i] <= hold_cnt_d[i];
      end
    end
  end

  // Gear keys: KEY_3 beats KEY_6 beats KEY_9 beats KEY_SHARP.
  always_ff @(posedge CLK or posedge global_safe_rst) begin
    if (global_safe_rst) begin
      gear_q     <= 4'd3;
      gear_vld_q <= 1'b0;
    end else begin
      gear_vld_q <= |(press_q & GEAR_MASK);
      if (press_q[2])       gear_q <= 4'd3;
      else if (press_q[5])  gear_q <= 4'd6;
      else if (press_q[8])  gear_q <= 4'd9;
      else if (press_q[11]) gear_q <= 4'd12;
    end
  end

  assign kp.key_level      = level_q;
  assign kp.key_press      = press_q;
  assign kp.key_release    = release_q;
  assign kp.key_hold       = hold_q;
  assign kp.gear_req       = gear_q;
  assign kp.gear_req_valid = gear_vld_q;

endmodule

// File: tb/tb_keypad_conditioner.sv
// Directed bench for keypad_conditioner at a 10-cycle ms tick, 4 ms debounce, 20 ms hold.
module tb_keypad_conditioner;

  logic clk;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  keypad_conditioner_if kp ();

  keypad_conditioner #(
    .CLK_HZ      (10_000),
    .DEBOUNCE_MS (4),
    .HOLD_MS     (20)
  ) dut (
    .CLK             (clk),
    .global_safe_rst (rst),
    .kp              (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) passed++;
    else $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
  endtask

  task automatic wait_level(input int b, input logic tgt, input int maxc, output int lat);
    int c;
    c   = 0;
    lat = -1;
    while (lat < 0 && c < maxc) begin
      @(negedge clk);
      c++;
      if (kp.key_level[b] === tgt) lat = c;
    end
  endtask

  task automatic gear_press(input logic [11:0] keys, input int b, input int code, input string tag);
    int lat;
    int extra;
    kp.key_raw = kp.key_raw | keys;
    wait_level(b, 1'b1, 50, lat);
    chk_range({tag, "_lat"}, lat, 31, 42);
    chk({tag, "_press"}, kp.key_press, keys);
    chk({tag, "_vld_early"}, kp.gear_req_valid, 0);
    @(negedge clk);
    chk({tag, "_vld"}, kp.gear_req_valid, 1);
    chk({tag, "_code"}, kp.gear_req, code);
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      extra += int'(kp.gear_req_valid);
    end
    chk({tag, "_no_repeat"}, extra, 0);
    kp.key_raw = kp.key_raw & ~keys;
    wait_level(b, 1'b0, 50, lat);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [11:0] acc;
    logic        vacc;
    logic        prev_hold;
    int          lat, lat1, hlat, pcount, c, npre;

    rst        = 1'b1;
    kp.key_raw = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_level", kp.key_level, 0);
    chk("rst_gear", kp.gear_req, 3);
    rst = 1'b0;

    // Idle after reset: nothing may move.
    acc  = '0;
    vacc = 1'b0;
    repeat (100) begin
      @(negedge clk);
      acc  = acc | kp.key_level | kp.key_press | kp.key_release | kp.key_hold;
      vacc = vacc | kp.gear_req_valid;
    end
    chk("idle_keys", acc, 0);
    chk("idle_vld", vacc, 0);
    chk("idle_gear", kp.gear_req, 3);

    // Clean KEY_0 press and release.
    kp.key_raw[10] = 1'b1;
    wait_level(10, 1'b1, 50, lat);
    chk_range("k0_press_lat", lat, 31, 42);
    chk("k0_press", kp.key_press, 12'h400);
    @(negedge clk);
    chk("k0_press_one", kp.key_press, 0);
    chk("k0_level_held", kp.key_level, 12'h400);
    kp.key_raw[10] = 1'b0;
    vacc = 1'b0;
    wait_level(10, 1'b0, 50, lat);
    chk_range("k0_rel_lat", lat, 31, 42);
    chk("k0_release", kp.key_release, 12'h400);
    chk("k0_rel_nopress", kp.key_press, 0);
    @(negedge clk);
    chk("k0_release_one", kp.key_release, 0);
    chk("k0_gear_quiet", kp.gear_req_valid, 0);

    // KEY_STAR bouncing with 15-cycle segments, then settling high.
    pcount = 0;
    acc    = '0;
    kp.key_raw[9] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (i > 0 && i % 15 == 0) kp.key_raw[9] = ~kp.key_raw[9];
      @(negedge clk);
      pcount += int'(kp.key_press[9]);
      acc     = acc | kp.key_level;
    end
    chk("bounce_no_press", pcount, 0);
    chk("bounce_no_level", acc, 0);
    kp.key_raw[9] = 1'b1;
    pcount = 0;
    repeat (42) begin
      @(negedge clk);
      pcount += int'(kp.key_press[9]);
    end
    chk("settle_one_press", pcount, 1);
    chk("settle_level", kp.key_level[9], 1);
    kp.key_raw[9] = 1'b0;
    wait_level(9, 1'b0, 50, lat);

    // KEY_1 held 300 cycles: hold flag after 20 ticks, cleared with the level.
    kp.key_raw[0] = 1'b1;
    wait_level(0, 1'b1, 50, lat1);
    chk_range("k1_lat", lat1, 31, 42);
    hlat = -1;
    c    = 0;
    while (hlat < 0 && c < 260) begin
      @(negedge clk);
      c++;
      if (kp.key_hold[0] === 1'b1) hlat = c;
    end
    chk_range("hold_lat", hlat, 190, 210);
    repeat (300 - lat1 - hlat) @(negedge clk);
    chk("hold_still", kp.key_hold, 12'h001);
    kp.key_raw[0] = 1'b0;
    prev_hold = 1'b0;
    lat = -1;
    c   = 0;
    while (lat < 0 && c < 50) begin
      @(negedge clk);
      c++;
      if (kp.key_level[0] === 1'b0) lat = c;
      else prev_hold = kp.key_hold[0];
    end
    chk("hold_before_fall", prev_hold, 1);
    chk("hold_cleared", kp.key_hold[0], 0);
    chk("hold_release", kp.key_release[0], 1);
    repeat (3) @(negedge clk);

    // Gear requests.
    gear_press(12'h800, 11, 12, "sharp");
    gear_press(12'h024, 2, 3, "k3k6");
    gear_press(12'h100, 8, 9, "k9");
    gear_press(12'h100, 8, 9, "k9_again");

    // KEY_5 held into reset.
    kp.key_raw[4] = 1'b1;
    wait_level(4, 1'b1, 50, lat);
    hlat = -1;
    c    = 0;
    while (hlat < 0 && c < 230) begin
      @(negedge clk);
      c++;
      if (kp.key_hold[4] === 1'b1) hlat = c;
    end
    chk("k5_hold_before_rst", kp.key_hold[4], 1);
    rst = 1'b1;
    #1;
    chk("arst_level", kp.key_level, 0);
    chk("arst_hold", kp.key_hold, 0);
    chk("arst_gear", kp.gear_req, 3);
    chk("arst_pulses", kp.key_press | kp.key_release, 0);
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    npre = 0;
    lat  = -1;
    c    = 0;
    while (lat < 0 && c < 60) begin
      @(negedge clk);
      c++;
      if (kp.key_level[4] === 1'b1) lat = c;
      else npre += int'(kp.key_press[4] | kp.key_release[4] | kp.gear_req_valid);
    end
    chk("post_rst_no_early_pulse", npre, 0);
    chk_range("post_rst_lat", lat, 31, 42);
    chk("post_rst_press", kp.key_press, 12'h010);
    kp.key_raw = '0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
